rv_ctrl: RTL
============

Name: rv_ctrl

Overview:
- Multicycle control FSM for the RV32I subset. It consumes the instruction register and ALU zero flag from the datapath, and drives every datapath select and enable plus the data-memory write strobe.
- One instruction takes 3–5 cycles. Unsupported opcodes stop the core in a sticky trap state.
- Also maintains a retired-instruction counter.

Parameters:
- DPWIDTH, 32, width of instr and instret.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  DPWIDTH  current IR contents.
- zero  in  1  combinational ALU result==0.
- pcsourse  out  1  0=PC+4, 1=ALU output register.
- pcwrite  out  1  PC load enable.
- pccen  out  1  PCC (instruction address copy) load enable.
- irwrite  out  1  IR load.
- wbsel  out  2  write-back select.
- regwen  out  1  register-file write enable.
- immsel  out  2  immediate format select.
- asel  out  1  ALU A select: 0=reg A, 1=PCC.
- bsel  out  1  ALU B select: 0=reg B, 1=imm.
- alusel  out  4  ALU operation.
- mdrwrite  out  1  MDR load.
- minussel  out  1  store negated B.
- dmem_wen  out  1  data-memory write strobe.
- halted  out  1  sticky trap indicator.
- instret  out  DPWIDTH  retired-instruction count.

Behaviour:
- State and instret registers reset asynchronously to FETCH and 0. All other outputs are Moore-decoded from state and instr.
- During and just after reset, outputs take their FETCH values. Inactive enables are 0; don't-care selects drive 0.
- States and outputs:
  - FETCH: irwrite=1, pccen=1, pcwrite=1, pcsourse=0. Next state DECODE.
  - DECODE: asel=1, bsel=1, alusel=ADD, immsel=IMM_J if opcode 1101111, else IMM_B. This precomputes the branch/jump target into ALU output register.
  - DECODE next state by opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011 (funct3 010)→MEM_ADDR; 0100011 (funct3 010 or 011)→MEM_ADDR; 1100011 (funct3 000/001)→BRANCH; 1101111→JAL. Anything else→TRAP.
  - EXEC_R: asel=0, bsel=0, alusel decoded from funct3 and instr[30]. Next state WB_ALU.
  - EXEC_I: asel=0, bsel=1, immsel=IMM_L, alusel decoded from funct3. instr[30] is used only when funct3=101 (SRAI); funct3=000 is always ADD. Next state WB_ALU.
  - WB_ALU: regwen=1, wbsel=WB_ALUOUT. Retire. Next state FETCH.
  - MEM_ADDR: asel=0, bsel=1, alusel=ADD; immsel=IMM_L for loads, IMM_S for stores. Next state MEM_RD for load, MEM_WR for store.
  - MEM_RD: mdrwrite=1 (memory read is combinational). Next state WB_MEM.
  - WB_MEM: regwen=1, wbsel=WB_MDR. Retire. Next state FETCH.
  - MEM_WR: dmem_wen=1, minussel=instr[12] (funct3 011 = custom SWN, stores −rs2). Retire. Next state FETCH.
  - BRANCH: asel=0, bsel=0, alusel=SUB. Taken when (funct3=000 and zero) or (funct3=001 and !zero). If taken: pcwrite=1, pcsourse=1; the ALU output register still holds the target computed in DECODE. Retire. Next state FETCH.
  - JAL: regwen=1, wbsel=WB_PC (PC already holds the link address), pcwrite=1, pcsourse=1. Retire. Next state FETCH.
  - TRAP: all enables 0, halted=1. Held until rst; instret frozen.
- Retire means instret increments by 1 at the end of that state's cycle. It wraps modulo 2^DPWIDTH.
- alusel decode:
  - 000 → ADD, or SUB when R-type and instr[30]=1.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRL, or SRA when instr[30]=1.
  - 110 → OR; 111 → AND.
- rd=x0 needs no special handling here; the datapath ignores writes to x0.
- rst asserted mid-instruction returns the FSM to FETCH immediately and clears instret and halted.

Decomposition:
- Shared include params.inc holds all encodings:
  - PC_PLUS4=0, PC_ALU=1.
  - WB_MDR=0, WB_ALUOUT=1, WB_PC=2.
  - IMM_J=0, IMM_B=1, IMM_S=2, IMM_L=3.
  - ALUA_REG=0, ALUA_PC=1; ALUB_REG=0, ALUB_IMM=1.
  - ALU_ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - The opcode constants and the state enum typedef also live there.
- One sub-module, rv_alu_dec (funct3/instr[30]/is_rtype → alusel), is natural; it is purely combinational.

Test Plan:
- Reset, then instr=0x002081B3 (ADD x3,x1,x2):
  - Cycle 0: irwrite=pccen=pcwrite=1, pcsourse=0.
  - Then DECODE (asel=1, bsel=1).
  - Then EXEC_R (alusel=0, asel=bsel=0).
  - Then WB_ALU (regwen=1, wbsel=1); instret 0→1.
- instr=0x402081B3 (SUB) → EXEC_R alusel=1. instr=0x4050D193 (SRAI) → EXEC_I alusel=7, bsel=1, immsel=3.
- instr=0x0000A183 (LW) → 5 cycles; mdrwrite=1 only in MEM_RD; WB_MEM regwen=1, wbsel=0.
- instr=0x0020B023 (SWN) → MEM_ADDR immsel=2, then MEM_WR dmem_wen=1, minussel=1; 4 cycles. With instr=0x0020A023 (SW), minussel=0.
- instr=0x00208463 (BEQ), zero=1 → BRANCH pcwrite=1, pcsourse=1. Repeat with zero=0 → pcwrite=0. Both retire.
- instr=0x008000EF (JAL) → DECODE immsel=0; JAL state regwen=1, wbsel=2, pcwrite=1, pcsourse=1.
- instr=0x00000000 → TRAP: halted=1, all enables 0 for 20 cycles, instret unchanged. Asserting rst returns to FETCH with halted=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: datapath selects,
// ALU operations, opcodes and the controller state type.
package rv_ctrl_pkg;

    localparam logic       PC_PLUS4  = 1'b0;
    localparam logic       PC_ALU    = 1'b1;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] IMM_J     = 2'd0;
    localparam logic [1:0] IMM_B     = 2'd1;
    localparam logic [1:0] IMM_S     = 2'd2;
    localparam logic [1:0] IMM_L     = 2'd3;

    localparam logic       ALUA_REG  = 1'b0;
    localparam logic       ALUA_PC   = 1'b1;
    localparam logic       ALUB_REG  = 1'b0;
    localparam logic       ALUB_IMM  = 1'b1;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_e;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode from funct3 and instr[30]; instr[30] selects SUB only
// for R-type, while it selects SRA for both R-type and immediate shifts.
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       bit30_i,
    input  logic       is_rtype_i,
    output logic [3:0] alusel_o
);

    always_comb begin
        unique case (funct3_i)
            3'b000:  alusel_o = (is_rtype_i && bit30_i) ? ALU_SUB : ALU_ADD;
            3'b001:  alusel_o = ALU_SLL;
            3'b010:  alusel_o = ALU_SLT;
            3'b011:  alusel_o = ALU_SLTU;
            3'b100:  alusel_o = ALU_XOR;
            3'b101:  alusel_o = bit30_i ? ALU_SRA : ALU_SRL;
            3'b110:  alusel_o = ALU_OR;
            default: alusel_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/rv_ctrl.sv
// Multicycle RV32I control FSM: Moore-decodes every datapath select/enable
// from the current state and IR, traps on unsupported opcodes, counts retirements.
module rv_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic               asel,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               minussel,
    output logic               dmem_wen,
    output logic               halted,
    output logic [DPWIDTH-1:0] instret
);

    state_e             state_q;
    logic [DPWIDTH-1:0] instret_q;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [3:0]         dec_alusel;
    logic               retire;
    logic               unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = &{1'b0, instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};
    assign retire       = state_q inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL};
    assign instret      = instret_q;

    rv_alu_dec u_alu_dec (
        .funct3_i   (funct3),
        .bit30_i    (instr[30]),
        .is_rtype_i (opcode == OP_RTYPE),
        .alusel_o   (dec_alusel)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            if (retire)
                instret_q <= instret_q + DPWIDTH'(1);
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:  state_q <= S_EXEC_R;
                        OP_ITYPE:  state_q <= S_EXEC_I;
                        OP_LOAD:   state_q <= (funct3 == 3'b010) ? S_MEM_ADDR : S_TRAP;
                        OP_STORE:  state_q <= (funct3[2:1] == 2'b01) ? S_MEM_ADDR : S_TRAP;
                        OP_BRANCH: state_q <= (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
                        OP_JAL:    state_q <= S_JAL;
                        default:   state_q <= S_TRAP;
                    endcase
                end
                S_EXEC_R, S_EXEC_I: state_q <= S_WB_ALU;
                S_MEM_ADDR: state_q <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_q <= S_WB_MEM;
                S_TRAP:     state_q <= S_TRAP;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        pcsourse = PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        wbsel    = WB_MDR;
        regwen   = 1'b0;
        immsel   = IMM_J;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        mdrwrite = 1'b0;
        minussel = 1'b0;
        dmem_wen = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pccen   = 1'b1;
                pcwrite = 1'b1;
            end
            // Branch/jump target is formed here and held in the ALU output register.
            S_DECODE: begin
                asel   = ALUA_PC;
                bsel   = ALUB_IMM;
                immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_EXEC_R: alusel = dec_alusel;
            S_EXEC_I: begin
                bsel   = ALUB_IMM;
                immsel = IMM_L;
                alusel = dec_alusel;
            end
            S_WB_ALU: begin
                regwen = 1'b1;
                wbsel  = WB_ALUOUT;
            end
            S_MEM_ADDR: begin
                bsel   = ALUB_IMM;
                immsel = (opcode == OP_LOAD) ? IMM_L : IMM_S;
            end
            S_MEM_RD: mdrwrite = 1'b1;
            S_WB_MEM: regwen = 1'b1;
            S_MEM_WR: begin
                dmem_wen = 1'b1;
                minussel = instr[12];
            end
            S_BRANCH: begin
                alusel = ALU_SUB;
                if (funct3[0] ? !zero : zero) begin
                    pcwrite  = 1'b1;
                    pcsourse = PC_ALU;
                end
            end
            S_JAL: begin
                regwen   = 1'b1;
                wbsel    = WB_PC;
                pcwrite  = 1'b1;
                pcsourse = PC_ALU;
            end
            S_TRAP:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule
